clz_clo_pipe: RTL

//   Pipelined, parametrised count-leading-zeros/ones unit for the CLZ/CLO

---
 rtl/clz_clo_pipe.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/clz_clo_pipe.sv
// Pipelined count-leading-zeros/ones unit: one binary-search halving level per stage,
// valid/ready handshake on both sides with backpressure and flush.
module clz_clo_pipe #(
    parameter int WIDTH = 32,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_count,
    output logic             out_all,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int L  = $clog2(WIDTH);
    localparam int CW = L + 1;

    logic [WIDTH-1:0] win_q [1:L];
    logic [WIDTH-1:0] win_d [1:L];
    logic [CW-1:0]    cnt_q [1:L];
    logic [CW-1:0]    cnt_d [1:L];
    logic [TAG_W-1:0] tag_q [1:L];
    logic [TAG_W-1:0] tag_d [1:L];
    logic [L:1]       vld_q;
    logic [L:1]       vld_d;
    logic             all_q;
    logic             all_d;

    // Views of each stage's source: index 0 is the (mode-normalised) entry operand.
    logic [WIDTH-1:0] win_v [0:L-1];
    logic [CW-1:0]    cnt_v [0:L-1];
    logic [TAG_W-1:0] tag_v [0:L-1];
    logic [L-1:0]     vld_v;

    logic [L:1]       adv;
    logic [L:1]       ld_ok;
    logic             s1_free;
    logic             in_fire;

    // Backward ready chain: a stage may load when it is empty or its beat moves on.
    always_comb begin
        logic f;
        f     = out_ready;
        adv   = '0;
        ld_ok = '0;
        for (int k = L; k >= 1; k--) begin
            adv[k]   = vld_q[k] && f;
            ld_ok[k] = !vld_q[k] || adv[k];
            f        = ld_ok[k];
        end
        s1_free = f;
    end

    assign in_ready = !rst && !flush && s1_free;
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        win_v[0] = in_mode ? ~in_data : in_data;
        cnt_v[0] = '0;
        tag_v[0] = in_tag;
        vld_v[0] = in_fire;
        for (int k = 1; k < L; k++) begin
            win_v[k] = win_q[k];
            cnt_v[k] = cnt_q[k];
            tag_v[k] = tag_q[k];
            vld_v[k] = vld_q[k];
        end
    end

    always_comb begin
        logic [WIDTH-1:0] w;
        logic [WIDTH-1:0] lo_mask;
        int               h;
        w       = '0;
        lo_mask = '0;
        h       = 0;
        win_d   = win_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        vld_d   = vld_q;
        all_d   = all_q;
        for (int k = 1; k <= L; k++) begin
            if (ld_ok[k]) begin
                vld_d[k] = vld_v[k-1];
                if (vld_v[k-1]) begin
                    w       = win_v[k-1];
                    h       = WIDTH >> k;
                    lo_mask = (WIDTH'(1) << h) - WIDTH'(1);
                    if ((w >> h) == '0) begin
                        win_d[k] = w & lo_mask;
                        cnt_d[k] = cnt_v[k-1] + CW'(h);
                    end else begin
                        win_d[k] = w >> h;
                        cnt_d[k] = cnt_v[k-1];
                    end
                    tag_d[k] = tag_v[k-1];
                    // Last level: a zero 1-bit window means the whole operand was zero.
                    if (k == L) begin
                        all_d    = ~win_d[k][0];
                        cnt_d[k] = cnt_d[k] + CW'(all_d);
                    end
                end
            end
        end
        if (flush) begin
            vld_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            all_q <= 1'b0;
            for (int k = 1; k <= L; k++) begin
                win_q[k] <= '0;
                cnt_q[k] <= '0;
                tag_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            all_q <= all_d;
            win_q <= win_d;
            cnt_q <= cnt_d;
            tag_q <= tag_d;
        end
    end

    assign out_valid = vld_q[L];
    assign out_count = OUT_W'(cnt_q[L]);
    assign out_all   = all_q;
    assign out_tag   = tag_q[L];
    assign busy      = |vld_q;

endmodule
